uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Samples the serial
//  line on oversampling ticks from the baud-rate generator and supports 5-9 data bits,
//  none/odd/even parity and 1/1.5/2 stop bits. Rejects glitched start bits and flags
//  parity, framing and overrun errors. Holds each received word behind a valid/ack
//  handshake for the downstream consumer (FIFO or interface FSM).
// PARAMETERS
//  DBIT     8   data bits per frame, 5..9, LSB received first
//  OVS      16  s_tick pulses per bit period (even, 8..16)
//  SB_TICK  16  s_tick count for the stop phase: OVS=1 stop, 1.5*OVS=1.5, 2*OVS=2
//  PARITY   0   0 none, 1 odd, 2 even
// PORTS
//  clk           in   1     system clock
//  reset         in   1     asynchronous, active-low reset
//  s_tick        in   1     one-clk enable, OVS pulses per bit
//  rx            in   1     serial line, asynchronous, idle high
//  rd_ack        in   1     consumer has taken dout; clears rx_valid
//  dout          out  DBIT  last received word
//  rx_done_tick  out  1     one-clk pulse when a frame completes
//  rx_valid      out  1     dout holds an unread word
//  parity_err    out  1     parity mismatch on the word in dout
//  frame_err     out  1     stop bit sampled low on the word in dout
//  overrun_err   out  1     sticky: frame completed while rx_valid=1
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, counters=0, synchroniser=1'b1,
//    dout=0, all flags=0. Asserting reset mid-frame aborts the frame. No done pulse.
//  - rx passes through a 2-flop synchroniser (rx_s, 2 clk latency). All FSM decisions
//    use rx_s. FSM state and counters advance only on clk edges with s_tick=1.
//  - s counter is 6 bits. n counter is 4 bits. Shift register is DBIT wide, shifts
//    right, and new bit enters at MSB.
//  - IDLE: on rx_s=0, clear s/n/shift and go to START.
//  - START: s counts 0..OVS/2-1. At s=OVS/2-1, if rx_s=0 then clear s and go to DATA.
//    Otherwise the start bit is a glitch: go to IDLE with no flag and no pulse.
//  - DATA: at s=OVS-1 (bit centre), shift in rx_s, set s=0 and n=n+1. After bit DBIT-1,
//    go to PARITY if PARITY!=0, else go to STOP.
//  - PARITY: at s=OVS-1, compute p_bad = (^shift ^ rx_s) != (PARITY==1). Set s=0 and
//    go to STOP.
//  - STOP: at s=OVS-1, latch stop_bad = ~rx_s. At s=SB_TICK-1, complete the frame and
//    go to IDLE.
//  - Frame completion, registered on the same clk edge:
//    - dout <= shift.
//    - parity_err <= p_bad, or 0 when PARITY=0.
//    - frame_err <= stop_bad.
//    - rx_done_tick high for exactly that one clk.
//    - rx_valid <= 1.
//    - if rx_valid was already 1 and no rd_ack arrives that cycle: overrun_err <= 1 and
//      dout is overwritten (newest word wins).
//  - rd_ack=1 clears rx_valid next clk. Completion and rd_ack in the same cycle: the
//    completion wins, rx_valid stays 1 and no overrun is flagged. overrun_err clears
//    only on rd_ack.
//  - rd_ack while rx_valid=0 has no effect.
//  - Errors never stop reception. A framed-error frame still returns to IDLE. A low
//    line then restarts at START (break = repeated frame_err frames).
//  - s_tick=0 freezes the FSM except the synchroniser and the rd_ack/flag logic.
// TESTING
//  1. 8N1, OVS=16, send 0xA5 -> one rx_done_tick; dout=0xA5, rx_valid=1, all errs 0;
//     done arrives 152 ticks (+2 clk) after the start edge.
//  2. DBIT=7, PARITY=2: send 0x37 with parity 1 -> parity_err=0. Send it with parity 0
//     -> parity_err=1, dout=0x37.
//  3. 8N1, stop bit driven low -> frame_err=1, dout correct. A following good 0x3C ->
//     frame_err=0.
//  4. Pulse rx low for 4 ticks -> back to IDLE, no done pulse, dout and flags unchanged.
//  5. Two frames 0x11 then 0x22, no rd_ack -> dout=0x22, overrun_err=1. rd_ack ->
//     rx_valid=0, overrun_err=0.
//  6. Assert reset in the middle of data bit 4 -> all outputs 0 immediately. After
//     release, a clean 0x5A frame -> dout=0x5A.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, none/odd/even parity, 1/1.5/2 stop bits.
// Oversampled on s_tick, with glitch rejection, error flags and a valid/ack word handshake.
module uart_rx_cfg #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rd_ack,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            rx_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [5:0] S_HALF = 6'(OVS/2 - 1);
  localparam logic [5:0] S_BIT  = 6'(OVS - 1);
  localparam logic [5:0] S_STOP = 6'(SB_TICK - 1);
  localparam logic [3:0] N_LAST = 4'(DBIT - 1);

  state_t            state_q;
  logic              rx_meta_q, rx_s_q;
  logic [5:0]        s_q;
  logic [3:0]        n_q;
  logic [DBIT-1:0]   shift_q;
  logic              p_bad_q, stop_bad_q;
  logic [DBIT-1:0]   dout_q;
  logic              done_q, valid_q, perr_q, ferr_q, ovr_q;

  logic              frame_done_d;
  logic              stop_bad_d;

  function automatic logic parity_bad(input logic [DBIT-1:0] word, input logic pbit);
    return ((^word) ^ pbit) != (PARITY == 1);
  endfunction

  // With SB_TICK == OVS the stop sample and the completion share one tick,
  // so the completion must see the stop bit being sampled right now.
  always_comb begin
    frame_done_d = s_tick && (state_q == STOP) && (s_q == S_STOP);
    stop_bad_d   = stop_bad_q;
    if (s_q == S_BIT) stop_bad_d = ~rx_s_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      s_q        <= '0;
      n_q        <= '0;
      shift_q    <= '0;
      p_bad_q    <= 1'b0;
      stop_bad_q <= 1'b0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      done_q    <= 1'b0;

      if (s_tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_s_q) begin
              s_q        <= '0;
              n_q        <= '0;
              shift_q    <= '0;
              p_bad_q    <= 1'b0;
              stop_bad_q <= 1'b0;
              state_q    <= START;
            end
          end
          START: begin
            if (s_q == S_HALF) begin
              s_q     <= '0;
              state_q <= rx_s_q ? IDLE : DATA;
            end else begin
              s_q <= s_q + 6'd1;
            end
          end
          DATA: begin
            if (s_q == S_BIT) begin
              s_q     <= '0;
              n_q     <= n_q + 4'd1;
              shift_q <= {rx_s_q, shift_q[DBIT-1:1]};
              if (n_q == N_LAST) state_q <= (PARITY != 0) ? PAR : STOP;
            end else begin
              s_q <= s_q + 6'd1;
            end
          end
          PAR: begin
            if (s_q == S_BIT) begin
              p_bad_q <= parity_bad(shift_q, rx_s_q);
              s_q     <= '0;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 6'd1;
            end
          end
          STOP: begin
            if (s_q == S_BIT) stop_bad_q <= ~rx_s_q;
            if (s_q == S_STOP) begin
              s_q     <= '0;
              state_q <= IDLE;
            end else begin
              s_q <= s_q + 6'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // Completion beats a same-cycle rd_ack; newest word always overwrites dout.
      if (frame_done_d) begin
        dout_q  <= shift_q;
        perr_q  <= (PARITY != 0) && p_bad_q;
        ferr_q  <= stop_bad_d;
        done_q  <= 1'b1;
        valid_q <= 1'b1;
        if (valid_q && !rd_ack) ovr_q <= 1'b1;
      end else if (rd_ack && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign rx_valid     = valid_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7-bit even-parity instance,
// with a scoreboard queue checked on every rx_done_tick.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       s_tick  = 1'b0;
  logic       line    = 1'b1;
  logic       sel7    = 1'b0;
  logic       ack8    = 1'b0;
  logic       ack7    = 1'b0;
  logic       rx8, rx7;
  assign rx8 = sel7 ? 1'b1 : line;
  assign rx7 = sel7 ? line : 1'b1;

  logic [7:0] dout8;
  logic       done8, valid8, perr8, ferr8, ovr8;
  logic [6:0] dout7;
  logic       done7, valid7, perr7, ferr7, ovr7;

  uart_rx_cfg #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY(0)) dut8 (
    .clk(clk), .reset(reset_n), .s_tick(s_tick), .rx(rx8), .rd_ack(ack8),
    .dout(dout8), .rx_done_tick(done8), .rx_valid(valid8),
    .parity_err(perr8), .frame_err(ferr8), .overrun_err(ovr8));

  uart_rx_cfg #(.DBIT(7), .OVS(16), .SB_TICK(16), .PARITY(2)) dut7 (
    .clk(clk), .reset(reset_n), .s_tick(s_tick), .rx(rx7), .rd_ack(ack7),
    .dout(dout7), .rx_done_tick(done7), .rx_valid(valid7),
    .parity_err(perr7), .frame_err(ferr7), .overrun_err(ovr7));

  // One s_tick every 4 clocks, changed on the falling edge.
  int tick_div = 0;
  int tick_num = 0;
  always @(negedge clk) begin
    tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
    s_tick   <= (tick_div == 3);
  end
  always @(posedge clk) if (s_tick) tick_num <= tick_num + 1;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t q8[$];
  exp_t q7[$];
  exp_t e8, e7;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt8 = 0;
  int done_cnt7 = 0;
  int done_at8 = 0;
  int start_tick = 0;
  int cnt_before = 0;
  int lat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      done_cnt8 <= done_cnt8 + 1;
      done_at8  <= tick_num;
      if (q8.size() == 0) check("sb8_unexpected_done", 1, 0);
      else begin
        e8 = q8.pop_front();
        check("sb8_dout", 32'(dout8), 32'(e8.d));
        check("sb8_parity_err", 32'(perr8), 32'(e8.pe));
        check("sb8_frame_err", 32'(ferr8), 32'(e8.fe));
        check("sb8_valid", 32'(valid8), 1);
      end
    end
    if (done7) begin
      done_cnt7 <= done_cnt7 + 1;
      if (q7.size() == 0) check("sb7_unexpected_done", 1, 0);
      else begin
        e7 = q7.pop_front();
        check("sb7_dout", 32'(dout7), 32'(e7.d));
        check("sb7_parity_err", 32'(perr7), 32'(e7.pe));
        check("sb7_frame_err", 32'(ferr7), 32'(e7.fe));
        check("sb7_valid", 32'(valid7), 1);
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (!s_tick);
    #1;
  endtask

  task automatic hold(input logic v, input int ticks);
    line = v;
    repeat (ticks) wait_tick();
  endtask

  task automatic send(input int nb, input logic [8:0] d, input bit has_p, input logic pb,
                      input logic sv);
    wait_tick();
    start_tick = tick_num;
    hold(1'b0, 16);
    for (int i = 0; i < nb; i++) hold(d[i], 16);
    if (has_p) hold(pb, 16);
    hold(sv, 16);
    hold(1'b1, 12);
  endtask

  task automatic push8(input logic [8:0] d, input logic fe);
    q8.push_back('{d: d, pe: 1'b0, fe: fe});
  endtask

  task automatic push7(input logic [8:0] d, input logic pb);
    // Even parity: the data bits plus the parity bit must hold an even count of ones.
    q7.push_back('{d: d, pe: logic'((($countones(d[6:0]) + int'(pb)) % 2) != 0), fe: 1'b0});
  endtask

  task automatic pulse_ack8();
    @(negedge clk); ack8 = 1'b1;
    @(negedge clk); ack8 = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout8"}, 32'(dout8), 0);
    check({tag, "_flags8"}, 32'({done8, valid8, perr8, ferr8, ovr8}), 0);
    check({tag, "_dout7"}, 32'(dout7), 0);
    check({tag, "_flags7"}, 32'({done7, valid7, perr7, ferr7, ovr7}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (8) wait_tick();

    // Test 1: 8N1 0xA5 with latency
    cnt_before = done_cnt8;
    push8(9'h0A5, 1'b0);
    send(8, 9'h0A5, 1'b0, 1'b0, 1'b1);
    lat = done_at8 - start_tick;
    check("t1_latency_ticks_in_152_153", 32'(lat >= 152 && lat <= 153), 1);
    check("t1_one_done_pulse", 32'(done_cnt8 - cnt_before), 1);
    check("t1_valid", 32'(valid8), 1);
    check("t1_errs", 32'({perr8, ferr8, ovr8}), 0);
    pulse_ack8();
    #1 check("t1_ack_clears_valid", 32'(valid8), 0);

    // Test 2: 7 data bits, even parity
    sel7 = 1'b1;
    push7(9'h037, 1'b1);
    send(7, 9'h037, 1'b1, 1'b1, 1'b1);
    check("t2_good_parity_err", 32'(perr7), 0);
    push7(9'h037, 1'b0);
    send(7, 9'h037, 1'b1, 1'b0, 1'b1);
    check("t2_bad_parity_err", 32'(perr7), 1);
    check("t2_bad_dout", 32'(dout7), 32'h37);
    check("t2_frames", 32'(done_cnt7), 2);
    sel7 = 1'b0;

    // Test 3: stop bit low, then a clean frame
    push8(9'h096, 1'b1);
    send(8, 9'h096, 1'b0, 1'b0, 1'b0);
    check("t3_frame_err", 32'(ferr8), 1);
    check("t3_dout", 32'(dout8), 32'h96);
    pulse_ack8();
    push8(9'h03C, 1'b0);
    send(8, 9'h03C, 1'b0, 1'b0, 1'b1);
    check("t3_frame_err_cleared", 32'(ferr8), 0);
    pulse_ack8();

    // Test 4: 4-tick glitch on the line
    cnt_before = done_cnt8;
    wait_tick();
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("t4_no_done", 32'(done_cnt8 - cnt_before), 0);
    check("t4_dout_kept", 32'(dout8), 32'h3C);
    check("t4_flags_kept", 32'({valid8, perr8, ferr8, ovr8}), 0);

    // Test 5: overrun
    push8(9'h011, 1'b0);
    send(8, 9'h011, 1'b0, 1'b0, 1'b1);
    check("t5_no_overrun_first", 32'(ovr8), 0);
    push8(9'h022, 1'b0);
    send(8, 9'h022, 1'b0, 1'b0, 1'b1);
    check("t5_overrun", 32'(ovr8), 1);
    check("t5_dout_newest", 32'(dout8), 32'h22);
    check("t5_valid", 32'(valid8), 1);
    pulse_ack8();
    #1 check("t5_ack_valid", 32'(valid8), 0);
    check("t5_ack_overrun", 32'(ovr8), 0);

    // Test 6: reset in the middle of data bit 4
    cnt_before = done_cnt8;
    wait_tick();
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold(logic'(i % 2), 16);
    hold(1'b1, 8);
    reset_n = 1'b0;
    #1 check_outputs_zero("t6_async_reset");
    line = 1'b1;
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) wait_tick();
    check("t6_no_done_aborted", 32'(done_cnt8 - cnt_before), 0);
    push8(9'h05A, 1'b0);
    send(8, 9'h05A, 1'b0, 1'b0, 1'b1);
    check("t6_dout", 32'(dout8), 32'h5A);
    check("t6_errs", 32'({perr8, ferr8, ovr8}), 0);

    check("end_q8_empty", 32'(q8.size()), 0);
    check("end_q7_empty", 32'(q7.size()), 0);
    check("end_frames8", 32'(done_cnt8), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
